// File: rtl/instruction_queue.sv
// Decoupling FIFO between decode and the out-of-order scheduler.
// Holds instruction + decode packet pairs and presents the oldest entry at the head.
module instruction_queue #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int QUEUE_DEPTH  = 4,
  localparam int PACKET_WIDTH = DATA_WIDTH + 3*ADDRESS_BITS + 38,
  localparam int PTR_W        = $clog2(QUEUE_DEPTH),
  localparam int CNT_W        = PTR_W + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   decode_instruction,
  input  logic [PACKET_WIDTH-1:0] decode_packet_in,
  input  logic                    decode_valid,
  output logic                    queue_ready,
  input  logic                    scheduler_ready,
  output logic [DATA_WIDTH-1:0]   instruction,
  output logic [PACKET_WIDTH-1:0] decode_packet,
  output logic                    queue_valid,
  output logic [CNT_W-1:0]        occupancy,
  output logic                    almost_full
);

  localparam logic [DATA_WIDTH-1:0] NOP          = DATA_WIDTH'(32'h0000_0013);
  localparam logic [CNT_W-1:0]      FULL_COUNT   = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0]      ALMOST_COUNT = CNT_W'(QUEUE_DEPTH - 1);

  logic [DATA_WIDTH-1:0]   instr_mem [QUEUE_DEPTH];
  logic [PACKET_WIDTH-1:0] packet_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    push;
  logic                    pop;

  // Handshakes use registered state only; a flush cancels both.
  always_comb begin
    queue_ready = (count != FULL_COUNT);
    queue_valid = (count != '0);
    push        = decode_valid & queue_ready & ~flush;
    pop         = scheduler_ready & queue_valid & ~flush;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset; the count alone defines which slots are live.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr]  <= decode_instruction;
      packet_mem[wr_ptr] <= decode_packet_in;
    end
  end

  always_comb begin
    instruction   = NOP;
    decode_packet = '0;
    if (queue_valid) begin
      instruction   = instr_mem[rd_ptr];
      decode_packet = packet_mem[rd_ptr];
    end
    occupancy   = count;
    almost_full = (count >= ALMOST_COUNT);
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: vector table plus a scoreboard
// of pushed entries compared against the head whenever the scheduler consumes.
module tb_instruction_queue;

  localparam int DW    = 32;
  localparam int PW    = 130;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic [DW-1:0] decode_instruction;
  logic [PW-1:0] decode_packet_in;
  logic          decode_valid;
  logic          queue_ready;
  logic          scheduler_ready;
  logic [DW-1:0] instruction;
  logic [PW-1:0] decode_packet;
  logic          queue_valid;
  logic [2:0]    occupancy;
  logic          almost_full;

  instruction_queue dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .decode_instruction (decode_instruction),
    .decode_packet_in   (decode_packet_in),
    .decode_valid       (decode_valid),
    .queue_ready        (queue_ready),
    .scheduler_ready    (scheduler_ready),
    .instruction        (instruction),
    .decode_packet      (decode_packet),
    .queue_valid        (queue_valid),
    .occupancy          (occupancy),
    .almost_full        (almost_full)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        dv;
    logic        sr;
    logic        fl;
    logic [31:0] instr;
    int          exp_occ;
    logic [31:0] exp_head;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [PW-1:0] pkt;
  } sb_t;

  vec_t vec [32];
  sb_t  sb [$];
  int   total_checks = 0;
  int   passed_checks = 0;

  // Packet low word carries the instruction so splitting is detectable.
  function automatic logic [PW-1:0] make_pkt(input logic [31:0] i);
    return {2'b10, ~i, {i[15:0], i[31:16]}, i ^ 32'h5A5A_5A5A, i};
  endfunction

  task automatic check_eq(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic checkOutput(input string tag, input int exp_occ, input logic [31:0] exp_head);
    logic [PW-1:0] exp_pkt;
    exp_pkt = (exp_occ == 0) ? '0 : make_pkt(exp_head);
    check_eq({tag, " occupancy"},   PW'(occupancy),   PW'(exp_occ));
    check_eq({tag, " queue_valid"}, PW'(queue_valid), PW'(exp_occ != 0));
    check_eq({tag, " queue_ready"}, PW'(queue_ready), PW'(exp_occ != DEPTH));
    check_eq({tag, " almost_full"}, PW'(almost_full), PW'(exp_occ >= DEPTH - 1));
    check_eq({tag, " instruction"}, PW'(instruction), PW'(exp_head));
    check_eq({tag, " packet"},      decode_packet,    exp_pkt);
  endtask

  // Called just after a falling edge; drives one cycle and returns at the next falling edge.
  task automatic applyStimulus(input logic dv, input logic sr, input logic fl, input logic [31:0] i);
    int   size_before;
    sb_t  entry;
    decode_valid       = dv;
    scheduler_ready    = sr;
    flush              = fl;
    decode_instruction = i;
    decode_packet_in   = make_pkt(i);
    #1;
    size_before = sb.size();
    if (fl) begin
      sb.delete();
    end else begin
      if (sr && size_before != 0) begin
        entry = sb.pop_front();
        check_eq("sb head instruction", PW'(instruction), PW'(entry.instr));
        check_eq("sb head packet", decode_packet, entry.pkt);
        check_eq("sb packet low word", PW'(decode_packet[31:0]), PW'(entry.instr));
      end
      if (dv && size_before != DEPTH) begin
        entry.instr = i;
        entry.pkt   = make_pkt(i);
        sb.push_back(entry);
      end
    end
    @(negedge clock);
    decode_valid    = 1'b0;
    scheduler_ready = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic add_row(input int n, input logic dv, input logic sr, input logic fl,
                         input logic [31:0] i, input int occ, input logic [31:0] head);
    vec[n] = '{dv: dv, sr: sr, fl: fl, instr: i, exp_occ: occ, exp_head: head};
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Fill, overfill, drain, empty pop.
    add_row(0,  1, 0, 0, 32'h0050_0093, 1, 32'h0050_0093);
    add_row(1,  1, 0, 0, 32'h00A0_0113, 2, 32'h0050_0093);
    add_row(2,  1, 0, 0, 32'h0020_81B3, 3, 32'h0050_0093);
    add_row(3,  1, 0, 0, 32'h0030_2023, 4, 32'h0050_0093);
    add_row(4,  1, 0, 0, 32'h0010_8093, 4, 32'h0050_0093);
    add_row(5,  0, 1, 0, 32'h0,         3, 32'h00A0_0113);
    add_row(6,  0, 1, 0, 32'h0,         2, 32'h0020_81B3);
    add_row(7,  0, 1, 0, 32'h0,         1, 32'h0030_2023);
    add_row(8,  0, 1, 0, 32'h0,         0, NOP);
    add_row(9,  0, 1, 0, 32'h0,         0, NOP);
    // Steady push+pop at occupancy 2, wrapping the pointers.
    add_row(10, 1, 0, 0, 32'h1000_0001, 1, 32'h1000_0001);
    add_row(11, 1, 0, 0, 32'h1000_0002, 2, 32'h1000_0001);
    add_row(12, 1, 1, 0, 32'h1000_0003, 2, 32'h1000_0002);
    add_row(13, 1, 1, 0, 32'h1000_0004, 2, 32'h1000_0003);
    add_row(14, 1, 1, 0, 32'h1000_0005, 2, 32'h1000_0004);
    add_row(15, 1, 1, 0, 32'h1000_0006, 2, 32'h1000_0005);
    add_row(16, 1, 1, 0, 32'h1000_0007, 2, 32'h1000_0006);
    add_row(17, 1, 1, 0, 32'h1000_0008, 2, 32'h1000_0007);
    // Full with simultaneous pop: the push is dropped, freed slot taken next cycle.
    add_row(18, 1, 0, 0, 32'h2000_0001, 3, 32'h1000_0007);
    add_row(19, 1, 0, 0, 32'h2000_0002, 4, 32'h1000_0007);
    add_row(20, 1, 1, 0, 32'h2000_0003, 3, 32'h1000_0008);
    add_row(21, 1, 0, 0, 32'h2000_0004, 4, 32'h1000_0008);
    add_row(22, 0, 1, 0, 32'h0,         3, 32'h2000_0001);
    add_row(23, 0, 1, 0, 32'h0,         2, 32'h2000_0002);
    add_row(24, 0, 1, 0, 32'h0,         1, 32'h2000_0004);
    add_row(25, 0, 1, 0, 32'h0,         0, NOP);
    // Flush at occupancy 3 with push and pop requested on the same edge.
    add_row(26, 1, 0, 0, 32'h3000_0001, 1, 32'h3000_0001);
    add_row(27, 1, 0, 0, 32'h3000_0002, 2, 32'h3000_0001);
    add_row(28, 1, 0, 0, 32'h3000_0003, 3, 32'h3000_0001);
    add_row(29, 1, 1, 1, 32'h3000_0004, 0, NOP);
    add_row(30, 1, 0, 0, 32'h3000_0005, 1, 32'h3000_0005);
    add_row(31, 0, 1, 0, 32'h0,         0, NOP);

    reset              = 1'b1;
    flush              = 1'b0;
    decode_valid       = 1'b0;
    scheduler_ready    = 1'b0;
    decode_instruction = '0;
    decode_packet_in   = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("reset idle", 0, NOP);

    for (int n = 0; n < 32; n++) begin
      applyStimulus(vec[n].dv, vec[n].sr, vec[n].fl, vec[n].instr);
      checkOutput($sformatf("row %0d", n), vec[n].exp_occ, vec[n].exp_head);
      check_eq($sformatf("row %0d model occupancy", n), PW'(occupancy), PW'(sb.size()));
    end

    // Async reset between edges at occupancy 2.
    applyStimulus(1, 0, 0, 32'h4000_0001);
    applyStimulus(1, 0, 0, 32'h4000_0002);
    checkOutput("pre async reset", 2, 32'h4000_0001);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset", 0, NOP);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("after reset release", 0, NOP);
    applyStimulus(1, 0, 0, 32'h4000_0003);
    checkOutput("push after reset", 1, 32'h4000_0003);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("drain after reset", 0, NOP);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Decoupling FIFO between the decode stage and the out-of-order scheduler.
- Buffers each decoded instruction together with its decode packet.
- Presents the oldest entry to the scheduler as instruction / decode_packet / queue_valid.
- Back-pressures decode when full; discards all contents on a pipeline flush (branch/jump redirect).

Parameters:
- DATA_WIDTH, 32, instruction and immediate width.
- ADDRESS_BITS, 20, PC/target address width.
- QUEUE_DEPTH, 4, number of entries; power of two, minimum 2.
- PACKET_WIDTH, DATA_WIDTH+3*ADDRESS_BITS+38, decode packet width (130 at defaults); derived, not overridden.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  discard all entries this cycle.
- decode_instruction  input  DATA_WIDTH  instruction from decode.
- decode_packet_in  input  PACKET_WIDTH  decode packet from decode.
- decode_valid  input  1  decode offers an entry.
- queue_ready  output  1  queue accepts an entry (not full).
- scheduler_ready  input  1  scheduler consumes the head entry.
- instruction  output  DATA_WIDTH  head instruction; NOP (32'h00000013) when empty.
- decode_packet  output  PACKET_WIDTH  head packet; all zeros when empty.
- queue_valid  output  1  head entry valid (not empty).
- occupancy  output  log2(QUEUE_DEPTH)+1  number of valid entries.
- almost_full  output  1  occupancy >= QUEUE_DEPTH-1.

Behaviour:
- Storage:
  - Circular buffer with read and write pointers of log2(QUEUE_DEPTH) bits, wrapping modulo QUEUE_DEPTH.
  - Separate count register, 0..QUEUE_DEPTH.
- Reset (async, asserted): pointers=0, count=0. Outputs:
  - queue_valid=0, queue_ready=1, occupancy=0, almost_full=0
  - instruction=NOP, decode_packet=0
  - Storage contents need not be cleared.
- Push: decode_valid & queue_ready at a clock edge writes both inputs at the write pointer, then increments it.
- Pop: queue_valid & scheduler_ready at a clock edge increments the read pointer.
- Head outputs are a combinational read of the read-pointer entry, gated to NOP/zero when count==0.
- No bypass. A push into an empty queue becomes visible at the head the cycle after the edge (1-cycle latency).
- queue_ready = (count != QUEUE_DEPTH), derived from registered state only. No dependence on scheduler_ready, so no combinational path from scheduler_ready to queue_ready.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop on the same edge: unchanged, both pointers advance.
- Full: queue_ready=0. decode_valid is ignored, even if a pop occurs the same cycle; the freed slot is offered on the next cycle.
- Empty: scheduler_ready is ignored; no pointer or count change.
- Flush (synchronous, highest priority after reset): pointers=0, count=0 at the edge. A push or pop on the same edge is discarded. queue_valid=0 on the following cycle.
- Ordering: strictly FIFO. The instruction and packet of one entry are never split across entries.
- Reset asserted mid-operation clears state immediately, independent of the clock. Deassertion resumes cleanly at the next edge.
- Pointer wrap: after QUEUE_DEPTH pushes, the write pointer returns to 0 with no gap or overwrite of unread entries.

Test Plan:
- Reset then idle:
  - reset high 2 cycles, then low -> queue_valid=0, queue_ready=1, occupancy=0, instruction=32'h00000013, decode_packet=0.
- Fill to full:
  - push 0x00500093, 0x00A00113, 0x002081B3, 0x00302023 with scheduler_ready=0 -> occupancy 1,2,3,4.
  - almost_full=1 from occupancy 3.
  - queue_ready=0 at 4; a 5th push (0x00108093) is dropped and occupancy stays 4.
- Drain order:
  - from full, hold scheduler_ready=1 -> head shows 0x00500093, 0x00A00113, 0x002081B3, 0x00302023 on successive cycles.
  - Then queue_valid=0 and instruction=NOP.
- Simultaneous push/pop at occupancy 2 for 6 cycles:
  - occupancy stays 2; outputs remain in order.
  - Pointers wrap past index 3 without corruption; packet bits [31:0] track their instruction.
- Flush:
  - with occupancy 3, assert flush together with decode_valid=1 and scheduler_ready=1 -> next cycle occupancy=0, queue_valid=0, queue_ready=1.
  - The next push appears at the head one cycle later.
- Async reset mid-fill:
  - assert reset between clock edges at occupancy 2 -> queue_valid=0 and occupancy=0 before the next rising edge.
